param_counter: RTL

Parametrised, registered up/down counter with a programmable inclusive upper bound, synchronous load, and three count modes: wrap, saturate, and ping-pong. It replaces the fixed 4-bit 0..7 wrap counter in the lab designs. It drives display digit counters, LED sequencers, and clock-divider terminal counts from a single module.

---
 rtl/param_counter.sv | 108 ++++++++++
 1 files changed

// File: rtl/param_counter.sv
// Parametrised up/down counter: wrap, saturate and ping-pong modes with a programmable inclusive bound.
// All outputs registered; one-cycle latency from the sampling edge; no flow control, steps whenever en is high.
module param_counter #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             up,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             dir_out
);

    typedef enum logic [1:0] {
        MODE_WRAP = 2'b00,
        MODE_SAT  = 2'b01,
        MODE_PING = 2'b10,
        MODE_HOLD = 2'b11
    } mode_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_out;
    logic             r_tc;
    logic             r_dir;

    logic             w_dir_act;
    logic             w_at_term;
    logic [WIDTH-1:0] w_next_out;
    logic             w_next_dir;
    logic [WIDTH-1:0] w_load_clamped;
    mode_t            w_mode;

    assign w_mode         = mode_t'(mode);
    assign w_dir_act      = (w_mode == MODE_PING) ? r_dir : up;
    // A count left above a freshly lowered bound is treated as terminal when going up.
    assign w_at_term      = w_dir_act ? (r_out >= max_val) : (r_out == '0);
    assign w_load_clamped = (load_val > max_val) ? max_val : load_val;

    always_comb begin
        w_next_out = r_out;
        w_next_dir = r_dir;
        case (w_mode)
            MODE_WRAP: begin
                w_next_dir = up;
                if (up) w_next_out = w_at_term ? '0 : r_out + ONE;
                else    w_next_out = w_at_term ? max_val : r_out - ONE;
            end
            MODE_SAT: begin
                w_next_dir = up;
                if (up) w_next_out = w_at_term ? max_val : r_out + ONE;
                else    w_next_out = w_at_term ? '0 : r_out - ONE;
            end
            MODE_PING: begin
                if (max_val == '0) begin
                    w_next_out = '0;
                    w_next_dir = 1'b1;
                end else if (r_dir) begin
                    if (w_at_term) begin
                        w_next_out = (r_out > max_val) ? max_val : max_val - ONE;
                        w_next_dir = 1'b0;
                    end else begin
                        w_next_out = r_out + ONE;
                    end
                end else begin
                    if (w_at_term) begin
                        w_next_out = ONE;
                        w_next_dir = 1'b1;
                    end else begin
                        w_next_out = r_out - ONE;
                    end
                end
            end
            default: begin
                w_next_out = r_out;
                w_next_dir = r_dir;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out <= RESET_VAL;
            r_tc  <= 1'b0;
            r_dir <= 1'b1;
        end else if (load) begin
            r_out <= w_load_clamped;
            r_tc  <= 1'b0;
        end else if (en && (w_mode != MODE_HOLD)) begin
            r_out <= w_next_out;
            r_dir <= w_next_dir;
            r_tc  <= w_at_term;
        end else begin
            r_tc  <= 1'b0;
        end
    end

    assign out     = r_out;
    assign tc      = r_tc;
    assign dir_out = r_dir;

endmodule
